// File: rtl/seq_gen_param.sv
// Multi-mode sequence generator (up, down, Gray, Fibonacci LFSR) on a valid/ready channel.
// Bursts have an optional length, a done pulse, and a wrap flag carried with each beat.
module seq_gen_param #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
   parameter int               LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [LEN_W-1:0] length,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] seq_out,
   output logic             wrap,
   output logic             done
);

   localparam logic [1:0] MODE_UP   = 2'd0;
   localparam logic [1:0] MODE_DOWN = 2'd1;
   localparam logic [1:0] MODE_GRAY = 2'd2;
   localparam logic [1:0] MODE_LFSR = 2'd3;

   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
   localparam logic [LEN_W-1:0] ZERO_L = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] ONE_L  = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0] MAX_L  = {LEN_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic [WIDTH-1:0] seed_q, seed_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] seq_out_q, seq_out_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;

   logic             accept;
   logic [WIDTH:0]   add_s;
   logic [WIDTH:0]   sub_s;
   logic [WIDTH-1:0] lfsr_s;
   logic [WIDTH-1:0] adv_val;
   logic             adv_wrap;
   logic [WIDTH-1:0] load_s;
   logic [WIDTH-1:0] start_val;
   logic [LEN_W-1:0] cnt_inc;
   logic             final_beat;

   // Advance value and wrap flag for the beat currently held, per the latched mode.
   always_comb begin
      add_s    = {1'b0, cur_q} + {1'b0, step_q};
      sub_s    = {1'b0, cur_q} - {1'b0, step_q};
      lfsr_s   = {cur_q[WIDTH-2:0], ^(cur_q & TAPS)};
      adv_val  = cur_q;
      adv_wrap = 1'b0;
      case (mode_q)
         MODE_UP: begin
            adv_val  = add_s[WIDTH-1:0];
            adv_wrap = add_s[WIDTH];
         end
         MODE_DOWN: begin
            adv_val  = sub_s[WIDTH-1:0];
            adv_wrap = sub_s[WIDTH];
         end
         MODE_GRAY: begin
            adv_val  = cur_q + ONE_W;
            adv_wrap = (cur_q == ONES_W);
         end
         MODE_LFSR: begin
            adv_val  = lfsr_s;
            adv_wrap = (lfsr_s == seed_q);
         end
         default: begin
            adv_val  = cur_q;
            adv_wrap = 1'b0;
         end
      endcase
   end

   // Start value and beat accounting; an all-zero LFSR seed would lock up, so it becomes 1.
   always_comb begin
      load_s     = load ? load_val : ZERO_W;
      start_val  = ((mode == MODE_LFSR) && (load_s == ZERO_W)) ? ONE_W : load_s;
      cnt_inc    = (cnt_q == MAX_L) ? cnt_q : (cnt_q + ONE_L);
      final_beat = (len_q != ZERO_L) && (cnt_inc == len_q);
      accept     = out_valid_q && out_ready;
   end

   // Next-state and registered-output logic of the burst FSM.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      seed_d      = seed_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      step_d      = step_q;
      len_d       = len_q;
      out_valid_d = out_valid_q;
      wrap_d      = wrap_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            seed_d      = start_val;
            out_valid_d = 1'b0;
            wrap_d      = 1'b0;
            if (en) begin
               state_d     = S_RUN;
               out_valid_d = 1'b1;
               cur_d       = start_val;
               cnt_d       = ZERO_L;
               mode_d      = mode;
               step_d      = step;
               len_d       = length;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (accept) begin
               cur_d  = adv_val;
               wrap_d = adv_wrap;
               cnt_d  = cnt_inc;
               // The final-beat rule wins over a simultaneous en drop so done still pulses.
               if (final_beat) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  wrap_d      = 1'b0;
                  done_d      = 1'b1;
               end else if (!en) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  wrap_d      = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end else if (!en) begin
               state_d = S_STOP;
            end else begin
               state_d = S_RUN;
            end
         end
         S_STOP: begin
            if (accept) begin
               cur_d       = adv_val;
               cnt_d       = cnt_inc;
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               wrap_d      = 1'b0;
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            wrap_d      = 1'b0;
         end
      endcase
      seq_out_d = (mode_d == MODE_GRAY) ? (cur_d ^ (cur_d >> 1)) : cur_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cur_q       <= ZERO_W;
         seed_q      <= ZERO_W;
         cnt_q       <= ZERO_L;
         mode_q      <= MODE_UP;
         step_q      <= ZERO_W;
         len_q       <= ZERO_L;
         out_valid_q <= 1'b0;
         seq_out_q   <= ZERO_W;
         wrap_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         seed_q      <= seed_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         step_q      <= step_d;
         len_q       <= len_d;
         out_valid_q <= out_valid_d;
         seq_out_q   <= seq_out_d;
         wrap_q      <= wrap_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign seq_out   = seq_out_q;
   assign wrap      = wrap_q;
   assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_param.sv
// Bench for seq_gen_param: transaction-level reference model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_seq_gen_param;

   localparam int WIDTH = 8;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             reset, en, load, out_ready;
   logic [1:0]       mode;
   logic [WIDTH-1:0] step, load_val;
   logic [LEN_W-1:0] length;
   logic             out_valid, wrap, done;
   logic [WIDTH-1:0] seq_out;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_gen_param #(.WIDTH(WIDTH), .TAPS(8'hB8), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .step(step),
      .load(load), .load_val(load_val), .length(length), .out_ready(out_ready),
      .out_valid(out_valid), .seq_out(seq_out), .wrap(wrap), .done(done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one burst is "active" while a beat is on offer; values follow plain arithmetic.
   bit m_vld, m_wrap, m_done, m_stop;
   int m_val, m_seed, m_cnt, l_mode, l_step, l_len;

   function automatic int lfsr_next(input int v);
      return ((v << 1) & 255) | ($countones(v & 32'hB8) & 1);
   endfunction

   always @(posedge clk) begin : model
      int nv;
      bit nw;
      int start;
      if (reset) begin
         m_vld = 0; m_wrap = 0; m_done = 0; m_stop = 0;
         m_val = 0; m_seed = 0; m_cnt = 0;
      end else begin
         m_done = 0;
         if (!m_vld) begin
            start = load ? int'(load_val) : 0;
            if (mode == 2'd3 && start == 0) start = 1;
            m_seed = start;
            if (en) begin
               m_vld = 1; m_val = start; m_wrap = 0; m_cnt = 0; m_stop = 0;
               l_mode = int'(mode); l_step = int'(step); l_len = int'(length);
            end
         end else if (out_ready) begin
            case (l_mode)
               0:       begin nv = m_val + l_step; nw = (nv > 255); end
               1:       begin nv = m_val - l_step; nw = (nv < 0);   end
               2:       begin nv = m_val + 1;      nw = (nv > 255); end
               default: begin nv = lfsr_next(m_val); nw = (nv == m_seed); end
            endcase
            m_val  = nv & 255;
            m_wrap = nw;
            m_cnt++;
            if (!m_stop && l_len != 0 && m_cnt == l_len) begin
               m_vld = 0; m_done = 1; m_wrap = 0;
            end else if (m_stop || !en) begin
               m_vld = 0; m_wrap = 0;
            end
         end else if (!en) begin
            m_stop = 1;
         end
      end
   end

   int q_val[$];
   bit q_wrap[$];
   int done_seen = 0;

   // Per-cycle comparison against the model, plus capture of accepted beats.
   always @(negedge clk) begin : compare
      int exp_seq;
      exp_seq = (l_mode == 2) ? (m_val ^ (m_val >> 1)) : m_val;
      check("out_valid", 32'(out_valid), 32'(m_vld));
      check("done", 32'(done), 32'(m_done));
      if (m_vld) begin
         check("seq_out", 32'(seq_out), 32'(exp_seq));
         check("wrap", 32'(wrap), 32'(m_wrap));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         q_val.push_back(int'(seq_out));
         q_wrap.push_back(wrap);
      end
      if (done === 1'b1) done_seen++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int md, input int st, input int lv, input int ln);
      q_val.delete();
      q_wrap.delete();
      mode = 2'(md); step = 8'(st); load = 1'b1; load_val = 8'(lv);
      length = 16'(ln); en = 1'b1; out_ready = 1'b1;
      tick();
   endtask

   task automatic collect(input int n);
      for (int i = 0; i < n * 4 + 20 && q_val.size() < n; i++) tick();
      check("collect_count", 32'(q_val.size() >= n), 32'd1);
      en = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100 && out_valid; i++) tick();
      en = 1'b0;
      check("back_to_idle", 32'(out_valid), 32'd0);
   endtask

   task automatic expect_beat(input string nm, input int idx, input int v, input int w);
      if (q_val.size() > idx) begin
         check(nm, 32'(q_val[idx]), 32'(v));
         check({nm, "_wrap"}, 32'(q_wrap[idx]), 32'(w));
      end else begin
         check({nm, "_present"}, 32'd0, 32'd1);
      end
   endtask

   initial begin
      int up_v[4]   = '{250, 253, 0, 3};
      int up_w[4]   = '{0, 0, 1, 0};
      int dn_v[3]   = '{2, 253, 248};
      int dn_w[3]   = '{0, 1, 0};
      int gr_v[8]   = '{0, 1, 3, 2, 6, 7, 5, 4};
      int lf_v[5]   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
      int bp_v[5]   = '{10, 11, 12, 13, 14};
      int d0;

      reset = 1'b1; en = 1'b1; mode = 2'd0; step = 8'd3; load = 1'b1;
      load_val = 8'd250; length = 16'd0; out_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_seq", 32'(seq_out), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      q_val.delete();
      q_wrap.delete();
      reset = 1'b0;
      tick();
      check("first_beat_valid", 32'(out_valid), 32'd1);
      check("first_beat_val", 32'(seq_out), 32'd250);
      collect(4);
      for (int i = 0; i < 4; i++) expect_beat("up", i, up_v[i], up_w[i]);
      wait_idle();

      start(1, 5, 2, 0);
      collect(3);
      for (int i = 0; i < 3; i++) expect_beat("down", i, dn_v[i], dn_w[i]);
      wait_idle();

      start(2, 0, 0, 0);
      collect(8);
      for (int i = 0; i < 8; i++) expect_beat("gray", i, gr_v[i], 0);
      wait_idle();

      start(3, 0, 0, 0);
      collect(256);
      for (int i = 0; i < 5; i++) expect_beat("lfsr", i, lf_v[i], 0);
      expect_beat("lfsr_period", 255, 1, 1);
      wait_idle();

      start(0, 1, 10, 0);
      for (int i = 0; i < 20 && !(out_valid && seq_out == 8'd12); i++) tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_hold_val", 32'(seq_out), 32'd12);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      collect(5);
      for (int i = 0; i < 5; i++) expect_beat("bp", i, bp_v[i], 0);
      wait_idle();

      d0 = done_seen;
      start(0, 1, 0, 4);
      wait_idle();
      check("burst_done_level", 32'(done), 32'd1);
      tick();
      check("burst_count", 32'(q_val.size()), 32'd4);
      for (int i = 0; i < 4; i++) expect_beat("burst", i, i, 0);
      check("burst_done_pulses", 32'(done_seen - d0), 32'd1);

      d0 = done_seen;
      start(0, 1, 0, 0);
      for (int i = 0; i < 20 && !(out_valid && seq_out == 8'd7); i++) tick();
      out_ready = 1'b0;
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      tick();
      check("stop_hold_val", 32'(seq_out), 32'd7);
      check("stop_hold_valid", 32'(out_valid), 32'd1);
      en = 1'b0;
      out_ready = 1'b1;
      tick();
      check("stop_idle", 32'(out_valid), 32'd0);
      tick();
      check("stop_no_done", 32'(done_seen - d0), 32'd0);
      if (q_val.size() > 0) check("stop_last_beat", 32'(q_val[q_val.size()-1]), 32'd7);
      else check("stop_last_present", 32'd0, 32'd1);

      for (int c = 0; c < 4000; c++) begin
         reset     = ($urandom_range(0, 199) == 0);
         en        = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         mode      = 2'($urandom_range(0, 3));
         step      = 8'($urandom);
         load      = 1'($urandom_range(0, 1));
         load_val  = 8'($urandom);
         length    = 16'($urandom_range(0, 6));
         tick();
      end
      reset = 1'b0;
      en = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
